// File: rtl/ram_op_enum.sv
// Shared encodings for the memory-access controller: access size/sign and FSM states.
package ram_op_enum;

   localparam int unsigned BE_W = 4;

   typedef enum logic [2:0] {
      SEL_B  = 3'b000,
      SEL_H  = 3'b001,
      SEL_W  = 3'b010,
      SEL_BU = 3'b100,
      SEL_HU = 3'b101
   } sel_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } state_e;

   // Misaligned halfword/word, or an encoding outside the legal set.
   function automatic logic access_err(input logic [2:0] sel, input logic [1:0] a);
      case (sel)
         SEL_B, SEL_BU: return 1'b0;
         SEL_H, SEL_HU: return a[0];
         SEL_W:         return a != 2'b00;
         default:       return 1'b1;
      endcase
   endfunction

   function automatic logic [BE_W-1:0] store_be(input logic [2:0] sel, input logic [1:0] a);
      case (sel)
         SEL_B, SEL_BU: return BE_W'(4'b0001 << a);
         SEL_H, SEL_HU: return BE_W'(4'b0011 << a);
         SEL_W:         return 4'b1111;
         default:       return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/ma_load_ext.sv
// Load lane extract: picks the addressed byte/halfword and sign- or zero-extends it.
module ma_load_ext
   import ram_op_enum::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] data,
   input  logic [2:0]      sel,
   input  logic [1:0]      addr,
   output logic [XLEN-1:0] rdata
);

   logic [XLEN-1:0] lane;

   assign lane = data >> {addr, 3'b000};

   always_comb begin
      rdata = '0;
      case (sel)
         SEL_B:   rdata = {{(XLEN-8){lane[7]}}, lane[7:0]};
         SEL_H:   rdata = {{(XLEN-16){lane[15]}}, lane[15:0]};
         SEL_BU:  rdata = XLEN'(lane[7:0]);
         SEL_HU:  rdata = XLEN'(lane[15:0]);
         SEL_W:   rdata = lane;
         default: rdata = '0;
      endcase
   end

endmodule

// File: rtl/ma_dram_ctrl.sv
// Two-requester data-RAM controller: round-robin accept, one RAM access, one response pulse.
module ma_dram_ctrl
   import ram_op_enum::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned AW   = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [1:0]           req_valid_i,
   output logic [1:0]           req_ready_o,
   input  logic [1:0]           req_wr_en_i,
   input  logic [1:0][2:0]      req_sel_i,
   input  logic [1:0][AW-1:0]   req_addr_i,
   input  logic [1:0][XLEN-1:0] req_wdata_i,
   output logic [1:0]           rsp_valid_o,
   output logic [XLEN-1:0]      rsp_rdata_o,
   output logic                 rsp_err_o,
   output logic [AW-3:0]        dram_addr_o,
   output logic                 dram_rd_en_o,
   output logic [BE_W-1:0]      dram_wr_byte_en_o,
   output logic [XLEN-1:0]      dram_wr_data_o,
   input  logic [XLEN-1:0]      dram_rd_data_i
);

   state_e          state, state_nxt;
   logic            last_grant;
   logic            grant;
   logic            accept;
   logic            owner;
   logic [AW-1:0]   addr_q;
   logic [2:0]      sel_q;
   logic            wr_q;
   logic [XLEN-1:0] wdata_q;
   logic            err_q;
   logic            err_c;
   logic [XLEN-1:0] load_data;

   // On a tie the requester that did not win last time gets the grant.
   always_comb begin
      grant = 1'b0;
      case (req_valid_i)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_grant;
         default: grant = 1'b0;
      endcase
   end

   assign accept = (state == ST_IDLE) && (req_valid_i != 2'b00);
   assign err_c  = access_err(sel_q, addr_q[1:0]);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         addr_q     <= '0;
         sel_q      <= 3'b000;
         wr_q       <= 1'b0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            last_grant <= grant;
            owner      <= grant;
            addr_q     <= req_addr_i[grant];
            sel_q      <= req_sel_i[grant];
            wr_q       <= req_wr_en_i[grant];
            wdata_q    <= req_wdata_i[grant];
         end
         if (state == ST_ACCESS) begin
            err_q <= err_c;
         end
      end
   end

   ma_load_ext #(.XLEN(XLEN)) u_load_ext (
      .data  (dram_rd_data_i),
      .sel   (sel_q),
      .addr  (addr_q[1:0]),
      .rdata (load_data)
   );

   // Outputs decode from state and the captured request; rdata needs the RAM word returned in RESP.
   always_comb begin
      state_nxt         = state;
      req_ready_o       = 2'b00;
      rsp_valid_o       = 2'b00;
      rsp_rdata_o       = '0;
      rsp_err_o         = 1'b0;
      dram_addr_o       = '0;
      dram_rd_en_o      = 1'b0;
      dram_wr_byte_en_o = '0;
      dram_wr_data_o    = '0;
      case (state)
         ST_IDLE: begin
            if (req_valid_i != 2'b00) begin
               req_ready_o[grant] = 1'b1;
               state_nxt          = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            dram_addr_o = addr_q[AW-1:2];
            if (!err_c) begin
               if (wr_q) begin
                  dram_wr_byte_en_o = store_be(sel_q, addr_q[1:0]);
                  dram_wr_data_o    = wdata_q << {addr_q[1:0], 3'b000};
               end else begin
                  dram_rd_en_o = 1'b1;
               end
            end
            state_nxt = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid_o[owner] = 1'b1;
            rsp_err_o          = err_q;
            if (!wr_q && !err_q) begin
               rsp_rdata_o = load_data;
            end
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ma_dram_ctrl.sv
// Directed vector bench for ma_dram_ctrl with a one-cycle-latency RAM model.
module tb_ma_dram_ctrl;

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 16;

   logic                 clk = 1'b0;
   logic                 rst_i;
   logic [1:0]           req_valid_i;
   logic [1:0]           req_ready_o;
   logic [1:0]           req_wr_en_i;
   logic [1:0][2:0]      req_sel_i;
   logic [1:0][AW-1:0]   req_addr_i;
   logic [1:0][XLEN-1:0] req_wdata_i;
   logic [1:0]           rsp_valid_o;
   logic [XLEN-1:0]      rsp_rdata_o;
   logic                 rsp_err_o;
   logic [AW-3:0]        dram_addr_o;
   logic                 dram_rd_en_o;
   logic [3:0]           dram_wr_byte_en_o;
   logic [XLEN-1:0]      dram_wr_data_o;
   logic [XLEN-1:0]      dram_rd_data_i;
   logic [XLEN-1:0]      ram_word;

   always #5 clk = ~clk;

   ma_dram_ctrl #(.XLEN(XLEN), .AW(AW)) dut (
      .clk_i             (clk),
      .rst_i             (rst_i),
      .req_valid_i       (req_valid_i),
      .req_ready_o       (req_ready_o),
      .req_wr_en_i       (req_wr_en_i),
      .req_sel_i         (req_sel_i),
      .req_addr_i        (req_addr_i),
      .req_wdata_i       (req_wdata_i),
      .rsp_valid_o       (rsp_valid_o),
      .rsp_rdata_o       (rsp_rdata_o),
      .rsp_err_o         (rsp_err_o),
      .dram_addr_o       (dram_addr_o),
      .dram_rd_en_o      (dram_rd_en_o),
      .dram_wr_byte_en_o (dram_wr_byte_en_o),
      .dram_wr_data_o    (dram_wr_data_o),
      .dram_rd_data_i    (dram_rd_data_i)
   );

   // RAM returns the word one cycle after the read strobe.
   always @(posedge clk) begin
      if (dram_rd_en_o) dram_rd_data_i <= ram_word;
   end

   typedef struct {
      logic        port;
      logic        wr;
      logic [2:0]  sel;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] ram;
      logic [3:0]  be;
      logic        rd;
      logic [31:0] wd;
      logic [13:0] daddr;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   vec_t vecs[13];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      req_valid_i = 2'b00;
      req_wr_en_i = 2'b00;
      req_sel_i   = '0;
      req_addr_i  = '0;
      req_wdata_i = '0;
   endtask

   task automatic drive(input logic p, input logic wr, input logic [2:0] sel,
                        input logic [15:0] addr, input logic [31:0] wdata);
      req_valid_i[p] = 1'b1;
      req_wr_en_i[p] = wr;
      req_sel_i[p]   = sel;
      req_addr_i[p]  = addr;
      req_wdata_i[p] = wdata;
   endtask

   int   acc_cyc[$];
   logic acc_port[$];
   int   n_acc;
   int   n_rsp;
   int   c;
   logic p;
   logic exp_order[4];

   initial begin
      //          port wr  sel     addr      wdata         ram           be      rd   wd            daddr    rdata         err
      vecs[0]  = '{1'b0, 1'b1, 3'b000, 16'h0102, 32'h000000AB, 32'h0,        4'b0100, 1'b0, 32'h00AB0000, 14'h0040, 32'h0,        1'b0};
      vecs[1]  = '{1'b1, 1'b0, 3'b000, 16'h0003, 32'h0,        32'h80FFFF7F, 4'b0000, 1'b1, 32'h0,        14'h0000, 32'hFFFFFF80, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 3'b100, 16'h0003, 32'h0,        32'h80FFFF7F, 4'b0000, 1'b1, 32'h0,        14'h0000, 32'h00000080, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 3'b010, 16'h0006, 32'h0,        32'h12345678, 4'b0000, 1'b0, 32'h0,        14'h0001, 32'h0,        1'b1};
      vecs[4]  = '{1'b0, 1'b0, 3'b011, 16'h0000, 32'h0,        32'h12345678, 4'b0000, 1'b0, 32'h0,        14'h0000, 32'h0,        1'b1};
      vecs[5]  = '{1'b0, 1'b1, 3'b001, 16'h0012, 32'h1234BEEF, 32'h0,        4'b1100, 1'b0, 32'hBEEF0000, 14'h0004, 32'h0,        1'b0};
      vecs[6]  = '{1'b1, 1'b1, 3'b010, 16'h0020, 32'hDEADBEEF, 32'h0,        4'b1111, 1'b0, 32'hDEADBEEF, 14'h0008, 32'h0,        1'b0};
      vecs[7]  = '{1'b0, 1'b0, 3'b001, 16'h0002, 32'h0,        32'h80011234, 4'b0000, 1'b1, 32'h0,        14'h0000, 32'hFFFF8001, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 3'b101, 16'h0002, 32'h0,        32'h80011234, 4'b0000, 1'b1, 32'h0,        14'h0000, 32'h00008001, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 3'b010, 16'h0004, 32'h0,        32'hCAFEF00D, 4'b0000, 1'b1, 32'h0,        14'h0001, 32'hCAFEF00D, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 3'b001, 16'h0001, 32'h0000BEEF, 32'h0,        4'b0000, 1'b0, 32'h0,        14'h0000, 32'h0,        1'b1};
      vecs[11] = '{1'b1, 1'b0, 3'b000, 16'h0001, 32'h0,        32'h00007F00, 4'b0000, 1'b1, 32'h0,        14'h0000, 32'h0000007F, 1'b0};
      vecs[12] = '{1'b1, 1'b1, 3'b000, 16'h0007, 32'hFFFFFF5A, 32'h0,        4'b1000, 1'b0, 32'h5A000000, 14'h0001, 32'h0,        1'b0};
      exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};

      dram_rd_data_i = '0;
      ram_word       = '0;
      rst_i          = 1'b1;
      idle_inputs();
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      #1;
      chk("reset_ready",   32'(req_ready_o), 32'h0);
      chk("reset_rsp",     32'(rsp_valid_o), 32'h0);
      chk("reset_rdata",   rsp_rdata_o, 32'h0);
      chk("reset_err",     32'(rsp_err_o), 32'h0);
      chk("reset_rd_en",   32'(dram_rd_en_o), 32'h0);
      chk("reset_be",      32'(dram_wr_byte_en_o), 32'h0);
      chk("reset_wr_data", dram_wr_data_o, 32'h0);

      // Each vector: accept in IDLE, then ACCESS, then RESP, with request inputs scrambled after accept.
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         #1;
         chk("idle_rsp_valid", 32'(rsp_valid_o), 32'h0);
         chk("idle_rdata",     rsp_rdata_o, 32'h0);
         drive(vecs[i].port, vecs[i].wr, vecs[i].sel, vecs[i].addr, vecs[i].wdata);
         ram_word = vecs[i].ram;
         #1;
         chk("ready", 32'(req_ready_o), vecs[i].port ? 32'h2 : 32'h1);
         @(negedge clk);
         req_valid_i = 2'b00;
         req_wr_en_i = ~req_wr_en_i;
         req_sel_i   = '1;
         req_addr_i  = '1;
         req_wdata_i = '1;
         #1;
         chk("access_ready",   32'(req_ready_o), 32'h0);
         chk("access_daddr",   32'(dram_addr_o), 32'(vecs[i].daddr));
         chk("access_be",      32'(dram_wr_byte_en_o), 32'(vecs[i].be));
         chk("access_rd_en",   32'(dram_rd_en_o), 32'(vecs[i].rd));
         chk("access_wr_data", dram_wr_data_o, vecs[i].wd);
         @(negedge clk);
         #1;
         chk("resp_valid", 32'(rsp_valid_o), vecs[i].port ? 32'h2 : 32'h1);
         chk("resp_err",   32'(rsp_err_o), 32'(vecs[i].err));
         chk("resp_rdata", rsp_rdata_o, vecs[i].rdata);
         chk("resp_rd_en", 32'(dram_rd_en_o), 32'h0);
         idle_inputs();
      end

      // Both requesters valid throughout: alternate grants; the pulse lands in the third
      // cycle of each transaction (accept cycle, ACCESS, RESP), two cycles after accept.
      @(negedge clk);
      idle_inputs();
      drive(1'b0, 1'b0, 3'b010, 16'h0000, 32'h0);
      drive(1'b1, 1'b0, 3'b010, 16'h0004, 32'h0);
      ram_word = 32'h11223344;
      n_acc = 0;
      n_rsp = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         #1;
         if (req_ready_o != 2'b00) begin
            acc_cyc.push_back(cyc);
            acc_port.push_back(req_ready_o[1]);
            if (n_acc < 4) chk("rr_grant", 32'(req_ready_o[1]), 32'(exp_order[n_acc]));
            n_acc++;
         end
         if (rsp_valid_o != 2'b00) begin
            if (acc_cyc.size() > 0) begin
               c = acc_cyc.pop_front();
               p = acc_port.pop_front();
               chk("rr_latency",  32'(cyc - c), 32'd2);
               chk("rr_rsp_port", 32'(rsp_valid_o), p ? 32'h2 : 32'h1);
            end
            n_rsp++;
         end
         @(negedge clk);
         if (n_acc >= 4) req_valid_i = 2'b00;
      end
      chk("rr_accepts",   32'(n_acc), 32'd4);
      chk("rr_responses", 32'(n_rsp), 32'd4);

      // Reset during ACCESS of a port-0 load: no pulse, back in IDLE, port 0 wins the next tie.
      @(negedge clk);
      idle_inputs();
      drive(1'b0, 1'b0, 3'b010, 16'h0008, 32'h0);
      ram_word = 32'hA5A5A5A5;
      #1;
      chk("abort_ready", 32'(req_ready_o), 32'h1);
      @(negedge clk);
      #1;
      chk("abort_rd_en", 32'(dram_rd_en_o), 32'h1);
      rst_i = 1'b1;
      idle_inputs();
      @(negedge clk);
      rst_i = 1'b0;
      drive(1'b0, 1'b0, 3'b010, 16'h0000, 32'h0);
      drive(1'b1, 1'b0, 3'b010, 16'h0004, 32'h0);
      ram_word = 32'h5EED0001;
      #1;
      chk("abort_no_rsp",    32'(rsp_valid_o), 32'h0);
      chk("abort_tie_port0", 32'(req_ready_o), 32'h1);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("abort_rsp_quiet", 32'(rsp_valid_o), 32'h0);
      @(negedge clk);
      #1;
      chk("post_reset_rsp",   32'(rsp_valid_o), 32'h1);
      chk("post_reset_rdata", rsp_rdata_o, 32'h5EED0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
